dma_fifo_push_arbiter: RTL
==========================

Name: dma_fifo_push_arbiter

Overview:
- Shares one 8-deep x 56-bit register FIFO (push side) among NUM_REQ DMA requesters, e.g. per-channel descriptor/completion generators.
- Round-robin arbitration with a programmable per-grant burst limit and occupancy-based flow control, so the FIFO never overruns.
- Registered push interface drives the FIFO directly. The FIFO's pop side belongs to the downstream engine and is outside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 56, FIFO data width.
- DEPTH, 8, FIFO depth in entries; fifoDepth port width is 4.

Ports:
- clockCore  in  1  core clock; all logic is on its rising edge.
- resetCore  in  1  asynchronous, active-low reset.
- enable  in  1  arbitration enable.
- reqMask  in  NUM_REQ  per-requester enable; 1 = eligible.
- burstLimit  in  4  maximum beats per grant; 0 means 16.
- reqValid  in  NUM_REQ  requester i has a beat.
- reqData  in  NUM_REQ*DATA_W  beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- reqReady  out  NUM_REQ  beat accepted from requester i this cycle.
- fifoPush  out  1  push strobe to FIFO.
- fifoDataIn  out  DATA_W  data to FIFO.
- fifoDepth  in  4  current FIFO occupancy.
- fifoOverrun  in  1  FIFO overrun pulse.
- grantId  out  3  index of the current or last granted requester.
- busy  out  1  high in the BURST state.
- errOverrun  out  1  sticky overrun flag.
- errClear  in  1  clears errOverrun.
- beatCount  out  16  total accepted beats; wraps.

Behaviour:
- Reset (resetCore=0, async) values: reqReady=0, fifoPush=0, fifoDataIn=0, grantId=0, busy=0, errOverrun=0, beatCount=0, state=IDLE, burstCnt=0, lastGrant=NUM_REQ-1 (so req0 wins first).
- eligible[i] = reqValid[i] & reqMask[i] & enable.
- pending = fifoPush. space = (fifoDepth + pending) < DEPTH. Compute in 5 bits; fifoDepth values above DEPTH are treated as full.
- FSM IDLE:
  - If any eligible[i], pick the first eligible index searching from lastGrant+1 upward with modulo NUM_REQ wrap.
  - Register it into grantId and lastGrant, clear burstCnt, go to BURST. No beat is accepted in IDLE.
- FSM BURST:
  - reqReady[grantId] = eligible[grantId] & space (combinational). All other reqReady bits are 0.
  - Transfer occurs when reqValid & reqReady are both 1. On the next edge: fifoPush=1, fifoDataIn=reqData[grantId], burstCnt++, beatCount++.
  - Cycles with no transfer leave fifoPush=0 on the next edge. fifoDataIn holds its last value.
- Exit BURST to IDLE on the next edge when any of:
  - a transfer completes beat number burstLimit (0 means 16);
  - eligible[grantId]=0 (requester idle, masked, or enable low);
  - no transfer in a cycle because space=0 and another requester is eligible (yield; avoids head-of-line hold).
- Otherwise stay in BURST. The minimum gap between grants is one IDLE cycle.
- Push latency: one cycle from handshake to fifoPush.
- Requester rule: reqValid and reqData must be held until reqReady.
- Fairness: a requester that just exited is lowest priority in the next IDLE pick.
- Flow control guarantee: fifoPush is never asserted while the FIFO holds DEPTH entries.
- errOverrun: set on fifoOverrun. errClear clears it. If both occur in the same cycle, set wins.
- Mid-burst changes:
  - enable deassert: blocks the beat combinationally that cycle and returns to IDLE next edge. An already-registered fifoPush still completes.
  - reqMask change takes effect the same cycle.
- beatCount wraps 0xFFFF->0.
- busy = (state==BURST).

Test Plan:
- Reset; req0 only, 3 beats, burstLimit=4 → grantId=0; fifoPush pulses 3 times, each one cycle after its handshake; state back to IDLE; beatCount=3.
- All four valid continuously, burstLimit=2, FIFO popped every cycle → grant order 0,1,2,3,0; exactly 2 beats each; one IDLE cycle between grants.
- Pop held off, req1 streaming → exactly 8 pushes, then reqReady[1]=0 while fifoDepth=8; no fifoPush at depth 8; one pop → exactly one further beat accepted.
- burstLimit=0, single requester with 20 beats → 16-beat grant, IDLE cycle, then 4-beat grant.
- reqMask=4'b1010 with all valid → only 1 and 3 granted. Drop enable mid-burst → reqReady=0 that cycle, busy=0 next cycle.
- Force fifoOverrun pulse → errOverrun=1 and held. Assert errClear with a simultaneous overrun → stays 1. errClear alone → 0. Assert reset mid-burst → all outputs at reset values immediately.

Source files
------------

// File: rtl/dma_fifo_push_arbiter.sv
// dma_fifo_push_arbiter: round-robin burst arbiter feeding requester beats into a shared push FIFO
module dma_fifo_push_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 56,
  parameter int DEPTH   = 8
) (
  input  logic                      clockCore,
  input  logic                      resetCore,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        reqMask,
  input  logic [3:0]                burstLimit,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic                      fifoPush,
  output logic [DATA_W-1:0]         fifoDataIn,
  input  logic [3:0]                fifoDepth,
  input  logic                      fifoOverrun,
  output logic [2:0]                grantId,
  output logic                      busy,
  output logic                      errOverrun,
  input  logic                      errClear,
  output logic [15:0]               beatCount
);
  localparam int GW = $clog2(NUM_REQ);
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t              r_state, w_next;
  logic [GW-1:0]       r_grant, r_last, w_pick;
  logic [4:0]          r_burst_cnt, w_limit;
  logic [NUM_REQ-1:0]  w_eligible, w_others;
  logic                w_space, w_gnt_elig, w_xfer, w_last_beat, w_exit;
  logic [DATA_W-1:0]   w_data [NUM_REQ];

  assign w_eligible  = reqValid & reqMask & {NUM_REQ{enable}};
  assign w_space     = ({1'b0, fifoDepth} + {4'b0, fifoPush}) < 5'(DEPTH);
  assign w_gnt_elig  = w_eligible[r_grant];
  assign w_others    = w_eligible & ~(NUM_REQ'(1) << r_grant);
  assign w_xfer      = (r_state == S_BURST) && w_gnt_elig && w_space;
  assign w_limit     = (burstLimit == 4'd0) ? 5'd16 : {1'b0, burstLimit};
  assign w_last_beat = w_xfer && (r_burst_cnt + 5'd1 >= w_limit);
  assign w_exit      = w_last_beat || !w_gnt_elig || (!w_space && |w_others);
  assign grantId     = 3'(r_grant);

  // split the flat data bus into per-requester beats
  always_comb
    for (int i = 0; i < NUM_REQ; i++) w_data[i] = reqData[i*DATA_W +: DATA_W];

  // round-robin winner: scan downward so the nearest index after the last grant is assigned last
  always_comb begin
    w_pick = r_last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [GW-1:0] j;
      j = GW'((int'(r_last) + k) % NUM_REQ);
      if (w_eligible[j]) w_pick = j;
    end
  end

  // state register
  always_ff @(posedge clockCore or negedge resetCore)
    if (!resetCore) r_state <= S_IDLE;
    else r_state <= w_next;

  // next state: any eligible requester starts a grant, burst ends on limit, idle requester or yield
  always_comb
    w_next = (r_state == S_IDLE) ? (|w_eligible ? S_BURST : S_IDLE) : (w_exit ? S_IDLE : S_BURST);

  // outputs: only the granted requester may be ready, and only when the FIFO has room
  always_comb begin
    reqReady = w_xfer ? NUM_REQ'(1) << r_grant : '0;
    busy     = r_state == S_BURST;
  end

  // grant bookkeeping: capture the winner on leaving IDLE, count beats within the grant
  always_ff @(posedge clockCore or negedge resetCore)
    if (!resetCore) begin
      r_grant     <= '0;
      r_last      <= GW'(NUM_REQ - 1);
      r_burst_cnt <= '0;
    end else if (r_state == S_IDLE && |w_eligible) begin
      r_grant     <= w_pick;
      r_last      <= w_pick;
      r_burst_cnt <= '0;
    end else if (w_xfer) r_burst_cnt <= r_burst_cnt + 5'd1;

  // registered push port and running beat total
  always_ff @(posedge clockCore or negedge resetCore)
    if (!resetCore) begin
      fifoPush   <= 1'b0;
      fifoDataIn <= '0;
      beatCount  <= '0;
    end else begin
      fifoPush <= w_xfer;
      if (w_xfer) begin
        fifoDataIn <= w_data[r_grant];
        beatCount  <= beatCount + 16'd1;
      end
    end

  // sticky overrun flag, a new overrun beats a simultaneous clear
  always_ff @(posedge clockCore or negedge resetCore)
    if (!resetCore) errOverrun <= 1'b0;
    else errOverrun <= fifoOverrun | (errOverrun & ~errClear);
endmodule
